// File: rtl/bp_pkg.sv
// Shared counter type, constants and saturating-update helper for the branch predictor.
// Pure types/functions: no latency; no flow control.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_RESET = 2'b01;
    localparam cnt_t CNT_MAX   = 2'd3;

    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        cnt_t res;
        if (taken) begin
            res = (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
        end else begin
            res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup / EX feedback channel into the branch predictor.
// Prediction is combinational on the lookup; no backpressure, every pulse is consumed.
interface branch_predictor_if #(
    parameter int BIT_W = 32
);
    logic             lookup_valid;
    logic [BIT_W-1:0] lookup_pc;
    logic             predict_taken;
    logic             feedback_valid;
    logic             prediction_incorrect;
    logic             branch_taken;
    logic             flush;

    modport master (
        output lookup_valid, lookup_pc, feedback_valid, prediction_incorrect,
               branch_taken, flush,
        input  predict_taken
    );

    modport slave (
        input  lookup_valid, lookup_pc, feedback_valid, prediction_incorrect,
               branch_taken, flush,
        output predict_taken
    );
endinterface

// File: rtl/bp_idx_fifo.sv
// Circular queue of in-flight branch table indices with push/pop/flush and error strobes.
// Head visible combinationally, updates on the edge; full push without pop is dropped (overflow strobe).
module bp_idx_fifo
    import bp_pkg::*;
#(
    parameter  int IDX_W   = 4,
    parameter  int Q_DEPTH = 4,
    localparam int CNT_W   = $clog2(Q_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [IDX_W-1:0] head_idx_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

    logic [IDX_W-1:0] mem_q [Q_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, pop_ok, push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(Q_DEPTH));
    assign pop_ok  = pop_i && !empty;
    // A same-cycle pop or flush frees a slot, so a push is only refused when neither happens.
    assign push_ok = push_i && (flush_i || !full || pop_ok);

    assign overflow_o  = push_i && !push_ok;
    assign underflow_o = pop_i && empty;
    assign head_idx_o  = mem_q[head_q];
    assign empty_o     = empty;
    assign count_o     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
            if (push_ok) begin
                tail_d  = ptr_inc(tail_q);
                count_d = CNT_W'(1);
            end
        end else begin
            if (pop_ok)  head_d = ptr_inc(head_q);
            if (push_ok) tail_d = ptr_inc(tail_q);
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Q_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_ok) mem_q[tail_q] <= push_idx_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage 2-bit-counter branch predictor trained by in-order EX feedback; BP_BYPASS_EN forwards same-cycle updates.
// Prediction combinational (0 cycles), training on next edge; no backpressure, overflow/underflow are sticky flags.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BIT_W   = 32,
    parameter int IDX_W   = 4,
    parameter int Q_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    branch_predictor_if.slave            bp_if,
    output logic [$clog2(Q_DEPTH+1)-1:0] q_count_o,
    output logic                         err_overflow_o,
    output logic                         err_underflow_o
);
    localparam int ENTRIES = 1 << IDX_W;

    cnt_t             table_q [ENTRIES];
    logic [BIT_W-1:0] pc;
    logic             unused_pc_bits;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             actual_taken, upd_en, fifo_empty;
    logic             ovf_stb, unf_stb;
    logic             err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    cnt_t             upd_cnt;

    // Bit 0 is always zero for legal PCs; bit 1 distinguishes compressed instructions.
    assign pc             = bp_if.lookup_pc;
    assign lk_idx         = pc[IDX_W:1];
    assign unused_pc_bits = ^{pc[BIT_W-1:IDX_W+1], pc[0]};

    assign actual_taken = bp_if.branch_taken ^ bp_if.prediction_incorrect;
    assign upd_en       = bp_if.feedback_valid && !fifo_empty;
    assign upd_cnt      = sat_update(table_q[upd_idx], actual_taken);

`ifdef BP_BYPASS_EN
    assign bp_if.predict_taken = (upd_en && (upd_idx == lk_idx)) ? upd_cnt[1]
                                                                : table_q[lk_idx][1];
`else
    assign bp_if.predict_taken = table_q[lk_idx][1];
`endif

    bp_idx_fifo #(
        .IDX_W   (IDX_W),
        .Q_DEPTH (Q_DEPTH)
    ) u_idx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bp_if.lookup_valid),
        .push_idx_i  (lk_idx),
        .pop_i       (bp_if.feedback_valid),
        .flush_i     (bp_if.flush),
        .head_idx_o  (upd_idx),
        .empty_o     (fifo_empty),
        .count_o     (q_count_o),
        .overflow_o  (ovf_stb),
        .underflow_o (unf_stb)
    );

    assign err_ovf_d = err_ovf_q | ovf_stb;
    assign err_unf_d = err_unf_q | unf_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RESET;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (upd_en) table_q[upd_idx] <= upd_cnt;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_overflow_o  = err_ovf_q;
    assign err_underflow_o = err_unf_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed lookups/feedback with hand-computed expectations.
module tb_branch_predictor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] q_count;
    logic       err_ovf, err_unf;
    logic       chk_vld;

    branch_predictor_if #(.BIT_W(32)) bus ();

    branch_predictor #(.BIT_W(32), .IDX_W(4), .Q_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bp_if           (bus.slave),
        .q_count_o       (q_count),
        .err_overflow_o  (err_ovf),
        .err_underflow_o (err_unf)
    );

    always #5 clk = ~clk;

`ifdef BP_BYPASS_EN
    localparam logic BYP_EXP = 1'b1;
`else
    localparam logic BYP_EXP = 1'b0;
`endif

    typedef struct { string name; logic pred; } pred_t;
    typedef struct { string name; int cnt; logic ovf; logic unf; } stat_t;

    pred_t pred_q[$];
    stat_t stat_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_n = 0;

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin : monitor
        pred_t pe;
        stat_t se;
        if (bus.lookup_valid) begin
            checks++;
            if (pred_q.size() == 0) begin
                errors++;
                $display("FAIL pred_unexpected: prediction %0b presented with no expectation queued", bus.predict_taken);
            end else begin
                pe = pred_q.pop_front();
                if (bus.predict_taken !== pe.pred) begin
                    errors++;
                    $display("FAIL %s: predict_taken=%0b expected %0b", pe.name, bus.predict_taken, pe.pred);
                end
            end
        end
        if (chk_vld) begin
            if (stat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stat_unexpected: status strobe with no expectation queued");
            end else begin
                se = stat_q.pop_front();
                checks += 3;
                if (q_count !== 3'(se.cnt)) begin
                    errors++;
                    $display("FAIL %s_count: q_count=%0d expected %0d", se.name, q_count, se.cnt);
                end
                if (err_ovf !== se.ovf) begin
                    errors++;
                    $display("FAIL %s_ovf: err_overflow=%0b expected %0b", se.name, err_ovf, se.ovf);
                end
                if (err_unf !== se.unf) begin
                    errors++;
                    $display("FAIL %s_unf: err_underflow=%0b expected %0b", se.name, err_unf, se.unf);
                end
            end
        end
    end

    task automatic idle();
        bus.lookup_valid         = 1'b0;
        bus.lookup_pc            = '0;
        bus.feedback_valid       = 1'b0;
        bus.branch_taken         = 1'b0;
        bus.prediction_incorrect = 1'b0;
        bus.flush                = 1'b0;
    endtask

    // One cycle of stimulus; expected prediction queued when a lookup is issued.
    task automatic drive(input logic lv, input logic [31:0] pc, input logic exp,
                         input logic fv, input logic tk, input logic inc, input logic fl);
        step_n++;
        bus.lookup_valid         = lv;
        bus.lookup_pc            = pc;
        bus.feedback_valid       = fv;
        bus.branch_taken         = tk;
        bus.prediction_incorrect = inc;
        bus.flush                = fl;
        if (lv) pred_q.push_back('{$sformatf("pred#%0d_pc%0h", step_n, pc), exp});
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lk(input logic [31:0] pc, input logic exp);
        drive(1'b1, pc, exp, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fb(input logic tk, input logic inc);
        drive(1'b0, 32'h0, 1'b0, 1'b1, tk, inc, 1'b0);
    endtask

    task automatic chk(input string nm, input int cnt, input logic ovf, input logic unf);
        stat_q.push_back('{nm, cnt, ovf, unf});
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        chk_vld = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and training to saturation and back.
        chk("reset", 0, 0, 0);
        lk(32'h40, 0); fb(0, 1);
        lk(32'h40, 1); fb(0, 1);
        lk(32'h40, 1); fb(0, 1);
        lk(32'h40, 1); fb(0, 0);
        lk(32'h40, 1); fb(0, 0);
        lk(32'h40, 0); fb(0, 0);
        lk(32'h40, 0); fb(1, 1);
        chk("train", 0, 0, 0);

        // Aliasing (0x60 shares entry 0) and compressed PC (0x42 is entry 1).
        lk(32'h40, 0); fb(1, 0);
        lk(32'h40, 0); fb(1, 0);
        lk(32'h60, 1);
        lk(32'h42, 0);
        chk("alias", 2, 0, 0);
        fb(1, 0); fb(0, 0);

        // FIFO ordering: indices 8, 0, 8.
        lk(32'h10, 0); lk(32'h20, 1); lk(32'h30, 0);
        chk("order_fill", 3, 0, 0);
        fb(1, 0); fb(0, 1); fb(1, 0);
        chk("order_drain", 0, 0, 0);
        lk(32'h10, 1); lk(32'h42, 0); lk(32'h04, 0);
        fb(0, 0); fb(0, 0); fb(0, 0);
        chk("order_after", 0, 0, 0);

        // Overflow, push+pop while full, drain, underflow.
        repeat (5) lk(32'h04, 0);
        chk("overflow", 4, 1, 0);
        drive(1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop", 4, 1, 0);
        repeat (4) fb(0, 0);
        chk("drained", 0, 1, 0);
        fb(1, 0);
        chk("underflow", 0, 1, 1);

        // Flush together with feedback and a redirected lookup.
        lk(32'h10, 1); lk(32'h04, 0); lk(32'h40, 1);
        chk("pre_flush", 3, 1, 1);
        drive(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush", 1, 1, 1);
        fb(0, 0);
        lk(32'h80, 1); fb(0, 0);
        lk(32'h80, 0);
        lk(32'h10, 0); lk(32'h04, 0);
        fb(1, 0); fb(1, 0); fb(1, 0);
        chk("post_flush", 0, 1, 1);

        // Same-cycle lookup and update of the same entry.
        lk(32'h04, 0);
        drive(1'b1, 32'h04, BYP_EXP, 1'b1, 1'b1, 1'b0, 1'b0);
        lk(32'h04, 1);
        fb(1, 0);
        lk(32'h40, 1); lk(32'h10, 1);
        chk("pre_reset", 3, 1, 1);

        // Asynchronous reset between clock edges.
        stat_q.push_back('{"async_reset", 0, 1'b0, 1'b0});
        chk_vld = 1'b1;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lk(32'h04, 0); lk(32'h40, 0); lk(32'h10, 0);
        chk("post_reset", 3, 0, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (pred_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions and %0d status checks never observed, required 0 and 0",
                     pred_q.size(), stat_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
